// File: rtl/riscv_pkg.sv
// Shared definitions for the input-interrupt block: event modes, register offsets, defaults.
package riscv_pkg;

  typedef enum logic [1:0] {
    IRQ_OFF  = 2'b00,
    IRQ_RISE = 2'b01,
    IRQ_FALL = 2'b10,
    IRQ_BOTH = 2'b11
  } irq_mode_e;

  localparam logic [3:0] INIRQ_STATE = 4'h0;
  localparam logic [3:0] INIRQ_MODE  = 4'h4;
  localparam logic [3:0] INIRQ_PEND  = 4'h8;
  localparam logic [3:0] INIRQ_IE    = 4'hC;

  localparam int unsigned INIRQ_NCH_DEFAULT       = 4;
  localparam int unsigned INIRQ_DB_CYCLES_DEFAULT = 8;

  // Does a rise/fall on one channel qualify under its mode?
  function automatic logic irq_event(input irq_mode_e mode, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      IRQ_RISE: hit = rise;
      IRQ_FALL: hit = fall;
      IRQ_BOTH: hit = rise | fall;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/riscv_input_cond.sv
// One input channel: synchroniser, optional debounce, edge detect.
// RISCV_INPUT_IRQ_DEBOUNCE_EN selects the stable-count debounce; otherwise a single delay stage.
module riscv_input_cond
  import riscv_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = INIRQ_DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic synced;
  logic level_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
  end

`ifdef RISCV_INPUT_IRQ_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Level only follows the synchronised input after it has disagreed for DB_CYCLES clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (synced == level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      level <= synced;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  logic unused_db;
  assign unused_db = (DB_CYCLES == 0);

  always_ff @(posedge clk) begin
    if (rst) level <= 1'b0;
    else     level <= synced;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign rise_c = level & ~level_d;
  assign fall_c = ~level & level_d;

endmodule

// File: rtl/riscv_input_irq.sv
// Input interrupt controller: per-channel conditioning plus STATE/MODE/PEND/IE registers.
// Macro RISCV_INPUT_IRQ_DEBOUNCE_EN enables the per-channel debounce counters.
module riscv_input_irq
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NCH         = INIRQ_NCH_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = INIRQ_DB_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            enable,
  input  logic            write,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  input  logic [NCH-1:0]  in_i,
  output logic [NCH-1:0]  irq_o
);

  logic [NCH-1:0]   level;
  logic [NCH-1:0]   rise_c;
  logic [NCH-1:0]   fall_c;
  logic [NCH-1:0]   event_c;
  logic [2*NCH-1:0] mode_q;
  logic [NCH-1:0]   pend_q;
  logic [NCH-1:0]   ie_q;
  logic [NCH-1:0]   pend_kept_c;
  logic [XLEN-1:0]  rd_word_c;
  logic [3:0]       offs_c;
  logic             wr_c;
  logic             rd_c;
  logic             unused_bus;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    riscv_input_cond #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_cond (
      .clk    (clk),
      .rst    (rst),
      .in_raw (in_i[c]),
      .level  (level[c]),
      .rise_c (rise_c[c]),
      .fall_c (fall_c[c])
    );
    assign event_c[c] = irq_event(irq_mode_e'(mode_q[2*c +: 2]), rise_c[c], fall_c[c]);
  end

  assign wr_c       = sel & enable & write;
  assign rd_c       = sel & enable & ~write;
  assign offs_c     = {addr[3:2], 2'b00};
  assign unused_bus = ^{addr, wdata};

  // W1C clear is applied before new events are OR'd in, so a coincident event wins.
  assign pend_kept_c = (wr_c && offs_c == INIRQ_PEND) ? (pend_q & ~wdata[NCH-1:0]) : pend_q;

  always_comb begin
    rd_word_c = '0;
    case (offs_c)
      INIRQ_STATE: rd_word_c[NCH-1:0]   = level;
      INIRQ_MODE:  rd_word_c[2*NCH-1:0] = mode_q;
      INIRQ_PEND:  rd_word_c[NCH-1:0]   = pend_q;
      INIRQ_IE:    rd_word_c[NCH-1:0]   = ie_q;
      default:     rd_word_c            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      pend_q <= '0;
      ie_q   <= '0;
      rdata  <= '0;
      irq_o  <= '0;
    end else begin
      if (wr_c && offs_c == INIRQ_MODE) mode_q <= wdata[2*NCH-1:0];
      if (wr_c && offs_c == INIRQ_IE)   ie_q   <= wdata[NCH-1:0];
      pend_q <= pend_kept_c | event_c;
      if (rd_c) rdata <= rd_word_c;
      irq_o <= pend_q & ie_q;
    end
  end

endmodule

// File: tb/tb_riscv_input_irq.sv
// Self-checking bench for riscv_input_irq: directed scenarios plus randomized traffic against a cycle model.
module tb_riscv_input_irq;
  import riscv_pkg::*;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned NCH         = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DB_CYCLES   = 8;
`ifdef RISCV_INPUT_IRQ_DEBOUNCE_EN
  localparam bit          DEB = 1'b1;
  localparam int unsigned LAT = 11;   // 2 sync + 8 stable + 1 pend
`else
  localparam bit          DEB = 1'b0;
  localparam int unsigned LAT = 4;    // 2 sync + 1 delay + 1 pend
`endif

  logic            clk;
  logic            rst;
  logic            sel;
  logic            enable;
  logic            write;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic [NCH-1:0]  in_i;
  logic [NCH-1:0]  irq_o;

  riscv_input_irq #(
    .XLEN        (XLEN),
    .NCH         (NCH),
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .enable (enable),
    .write  (write),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .in_i   (in_i),
    .irq_o  (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  // Reference model state, expressed as the observable registers
  logic [NCH-1:0]   m_seen[$];       // raw inputs sampled since reset, oldest first
  int unsigned      m_run[NCH];      // consecutive cycles synced input disagreed with level
  logic [NCH-1:0]   m_lvl  = '0;
  logic [NCH-1:0]   m_prev = '0;
  logic [2*NCH-1:0] m_mode = '0;
  logic [NCH-1:0]   m_pend = '0;
  logic [NCH-1:0]   m_ie   = '0;
  logic [NCH-1:0]   m_irq  = '0;
  logic [XLEN-1:0]  m_rdata = '0;

  task automatic model_step();
    logic [NCH-1:0]   syn;
    logic [NCH-1:0]   lvl_n;
    logic [NCH-1:0]   ev;
    logic [NCH-1:0]   pend_n;
    logic [2*NCH-1:0] mode_n;
    logic [NCH-1:0]   ie_n;
    logic [XLEN-1:0]  rd_n;
    logic [1:0]       md;
    logic [1:0]       idx;
    logic             rise;
    logic             fall;
    if (rst) begin
      m_seen.delete();
      for (int c = 0; c < int'(NCH); c++) m_run[c] = 0;
      m_lvl = '0; m_prev = '0; m_mode = '0; m_pend = '0;
      m_ie = '0; m_irq = '0; m_rdata = '0;
      return;
    end
    // Synchronised value = raw input seen SYNC_STAGES edges ago (zero until the chain fills)
    syn = (m_seen.size() == int'(SYNC_STAGES)) ? m_seen[0] : '0;
    lvl_n = m_lvl;
    if (DEB) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if (syn[c] != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DB_CYCLES) begin
            lvl_n[c] = syn[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end else begin
      lvl_n = syn;
    end
    for (int c = 0; c < int'(NCH); c++) begin
      rise  = m_lvl[c] & ~m_prev[c];
      fall  = ~m_lvl[c] & m_prev[c];
      md    = m_mode[2*c +: 2];
      ev[c] = (rise & md[0]) | (fall & md[1]);
    end
    idx    = addr[3:2];
    rd_n   = m_rdata;
    mode_n = m_mode;
    ie_n   = m_ie;
    pend_n = m_pend;
    if (sel && enable && !write) begin
      case (idx)
        2'd0: rd_n = XLEN'(m_lvl);
        2'd1: rd_n = XLEN'(m_mode);
        2'd2: rd_n = XLEN'(m_pend);
        default: rd_n = XLEN'(m_ie);
      endcase
    end
    if (sel && enable && write) begin
      if (idx == 2'd1) mode_n = wdata[2*NCH-1:0];
      if (idx == 2'd3) ie_n   = wdata[NCH-1:0];
      if (idx == 2'd2) pend_n = pend_n & ~wdata[NCH-1:0];
    end
    pend_n  = pend_n | ev;
    m_irq   = m_pend & m_ie;
    m_prev  = m_lvl;
    m_lvl   = lvl_n;
    m_pend  = pend_n;
    m_mode  = mode_n;
    m_ie    = ie_n;
    m_rdata = rd_n;
    m_seen.push_back(in_i);
    if (m_seen.size() > int'(SYNC_STAGES)) void'(m_seen.pop_front());
  endtask

  always @(posedge clk) model_step();

  task automatic compare_outputs();
    compared = compared + 1;
    if (rdata !== m_rdata) begin
      mismatched = mismatched + 1;
      $display("FAIL rdata @%0t: got 0x%0h expected 0x%0h", $time, rdata, m_rdata);
    end
    compared = compared + 1;
    if (irq_o !== m_irq) begin
      mismatched = mismatched + 1;
      $display("FAIL irq_o @%0t: got 0x%0h expected 0x%0h", $time, irq_o, m_irq);
    end
  endtask

  always @(negedge clk) if (chk_en) compare_outputs();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    sel = 1'b0; enable = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    sel = 1'b1; enable = 1'b1; write = 1'b1; addr = XLEN'(off); wdata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] d);
    sel = 1'b1; enable = 1'b1; write = 1'b0; addr = XLEN'(off);
    @(negedge clk);
    bus_idle();
    d = rdata;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1; in_i = '0; addr = '0; wdata = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", 32'(irq_o), 32'h0);
    rst = 1'b0;

    // Single rising event on ch0: exact latency and irq lag
    wr(INIRQ_MODE, 32'h1);
    wr(INIRQ_IE, 32'h1);
    in_i[0] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    rd(INIRQ_PEND, d);
    check("ch0_pend_early", d, 32'h0);
    check("ch0_irq_at_pend", 32'(irq_o), 32'h0);
    rd(INIRQ_PEND, d);
    check("ch0_pend_set", d, 32'h1);
    check("ch0_irq_next", 32'(irq_o), 32'h1);
    repeat (15) @(negedge clk);
    rd(INIRQ_STATE, d);
    check("ch0_state", d, 32'h1);
    wr(INIRQ_PEND, 32'h1);
    in_i[0] = 1'b0;
    repeat (20) @(negedge clk);
    rd(INIRQ_PEND, d);
    check("ch0_fall_ignored", d, 32'h0);

    // Short pulse on ch1
    wr(INIRQ_MODE, 32'h4);
    in_i[1] = 1'b1;
    repeat (5) @(negedge clk);
    in_i[1] = 1'b0;
    repeat (20) @(negedge clk);
    rd(INIRQ_STATE, d);
    check("glitch_state", d, 32'h0);
    rd(INIRQ_PEND, d);
    check("glitch_pend", d, DEB ? 32'h0 : 32'h2);
    check("glitch_irq", 32'(irq_o), 32'h0);
    wr(INIRQ_PEND, 32'h2);

    // Both edges on ch2 with W1C between
    wr(INIRQ_MODE, 32'h30);
    in_i[2] = 1'b1;
    repeat (30) @(negedge clk);
    rd(INIRQ_PEND, d);
    check("ch2_rise_pend", d, 32'h4);
    wr(INIRQ_PEND, 32'h4);
    rd(INIRQ_PEND, d);
    check("ch2_w1c", d, 32'h0);
    in_i[2] = 1'b0;
    repeat (20) @(negedge clk);
    rd(INIRQ_PEND, d);
    check("ch2_fall_pend", d, 32'h4);
    wr(INIRQ_PEND, 32'h4);

    // W1C landing on the same edge as a new event: set wins
    wr(INIRQ_MODE, 32'h1);
    in_i[0] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    wr(INIRQ_PEND, 32'h1);
    rd(INIRQ_PEND, d);
    check("set_wins", d, 32'h1);
    wr(INIRQ_PEND, 32'h1);
    rd(INIRQ_PEND, d);
    check("set_wins_clear", d, 32'h0);

    // Masked pending bit, then enable
    wr(INIRQ_IE, 32'h0);
    wr(INIRQ_MODE, 32'hC0);
    in_i[3] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    rd(INIRQ_PEND, d);
    check("ch3_pend", d, 32'h8);
    check("ch3_masked_irq", 32'(irq_o), 32'h0);
    wr(INIRQ_IE, 32'h8);
    check("ch3_irq_lag", 32'(irq_o), 32'h0);
    @(negedge clk);
    check("ch3_irq_on", 32'(irq_o), 32'h8);

    // Reset in the middle of a debounce count
    in_i[1] = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_irq", 32'(irq_o), 32'h0);
    rd(INIRQ_STATE, d); check("mid_rst_state", d, 32'h0);
    rd(INIRQ_MODE, d);  check("mid_rst_mode", d, 32'h0);
    rd(INIRQ_PEND, d);  check("mid_rst_pend", d, 32'h0);
    rd(INIRQ_IE, d);    check("mid_rst_ie", d, 32'h0);
    repeat (30) @(negedge clk);
    rd(INIRQ_PEND, d);  check("post_rst_pend", d, 32'h0);
    rd(INIRQ_STATE, d); check("post_rst_state", d, 32'hB);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, (n < 2000) ? 3 : 14) == 0)
        in_i[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        bus_idle();
      end else begin
        sel    = ($urandom_range(0, 3) != 0);
        enable = ($urandom_range(0, 3) != 0);
        write  = ($urandom_range(0, 1) != 0);
        addr   = $urandom;
        wdata  = $urandom;
      end
      rst = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    bus_idle();
    rst = 1'b0;
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/riscv_input_irq.md
RISCV_INPUT_IRQ -- requirements
Module: riscv_input_irq

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data bus width.
REQ-002 SHALL have parameter NCH, default 4, range 1..16, meaning number of input channels.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, minimum 2, meaning synchroniser depth.
REQ-004 SHALL have parameter DB_CYCLES, default 8, minimum 2, meaning debounce stable-count length.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port sel, input, 1 bit: slave select from the bus controller.
REQ-008 SHALL have port enable, input, 1 bit: bus request.
REQ-009 SHALL have port write, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port addr, input, XLEN bits: byte address; only addr[3:2] is decoded.
REQ-011 SHALL have port wdata, input, XLEN bits: write data.
REQ-012 SHALL have port rdata, output, XLEN bits: read data.
REQ-013 SHALL have port in_i, input, NCH bits: asynchronous raw inputs (buttons, switches).
REQ-014 SHALL have port irq_o, output, NCH bits: per-channel interrupt lines to the core's external interrupt inputs.

Function
REQ-015 Each channel SHALL pass in_i through a SYNC_STAGES flop chain (ASYNC_REG) before any other use.
REQ-016 Debounce: a per-channel counter of width $clog2(DB_CYCLES)+1 SHALL clear whenever the synchronised value equals the debounced level.
REQ-017 Debounce: while the synchronised value differs from the debounced level, the counter SHALL increment; when it reaches DB_CYCLES-1, the debounced level SHALL take the new value and the counter SHALL clear.
REQ-018 Glitches shorter than DB_CYCLES clocks SHALL NOT change the debounced level.
REQ-019 Edge detection SHALL compare the debounced level with its value one cycle earlier.
REQ-020 MODE[2c+1:2c] SHALL select the event for channel c: 00 off, 01 rising, 10 falling, 11 both.
REQ-021 A qualifying event SHALL set PEND[c] exactly SYNC_STAGES+DB_CYCLES+1 clocks after a clean in_i transition.
REQ-022 Register map, one word each, unused bits read 0:
  - 0x0 STATE, RO: debounced levels.
  - 0x4 MODE, RW: 2*NCH bits.
  - 0x8 PEND, RW1C.
  - 0xC IE, RW.
REQ-023 A write SHALL occur when sel&enable&write, and SHALL take effect at that clock edge.
REQ-024 A read SHALL return the register in rdata one cycle after sel&enable&!write; otherwise rdata SHALL hold its last value.
REQ-025 If an event sets PEND[c] in the same cycle a W1C clears it, PEND[c] SHALL remain 1 (set wins).
REQ-026 irq_o SHALL be registered, equal PEND&IE, and lag both by one cycle.
REQ-027 Changing MODE SHALL NOT clear PEND.
REQ-028 Events SHALL be evaluated with the MODE value in effect on that cycle.

Reset
REQ-029 While rst=1, the following SHALL be 0 on the next edge: sync chains, debounce counters, debounced levels, edge history, MODE, PEND, IE, rdata, irq_o.
REQ-030 rst asserted mid-debounce SHALL discard the partial count.
REQ-031 After reset, an input held high SHALL produce a debounced rising edge; it SHALL NOT set PEND because MODE=00.

Configuration
REQ-032 With macro RISCV_INPUT_IRQ_DEBOUNCE_EN defined, the debounce of REQ-016..018 SHALL be present.
REQ-033 With RISCV_INPUT_IRQ_DEBOUNCE_EN undefined, the counters SHALL be omitted, the debounced level SHALL be the synchronised value delayed one cycle, DB_CYCLES SHALL be ignored, and event latency SHALL be SYNC_STAGES+2 clocks.

Structure
REQ-034 riscv_pkg SHALL hold:
  - the mode enum (IRQ_OFF, IRQ_RISE, IRQ_FALL, IRQ_BOTH);
  - register offset constants (INIRQ_STATE/MODE/PEND/IE);
  - default NCH and DB_CYCLES.
REQ-035 Per-channel sync/debounce/edge logic SHALL be sub-module riscv_input_cond, instantiated NCH times via generate.
REQ-036 The top module SHALL hold only registers, bus decode and irq_o.

Verification (NCH=4, SYNC_STAGES=2, DB_CYCLES=8, macro defined)
REQ-037 MODE=0x1, IE=0x1, in_i[0] 0->1 held 20 cycles -> PEND=0x1 at +11 clocks, irq_o[0]=1 at +12, STATE reads 0x1.
REQ-038 in_i[1] high for 5 cycles only, MODE=0x4 -> STATE, PEND, irq_o stay 0.
REQ-039 MODE=0x30, in_i[2] high 30 cycles then low -> PEND[2] set on the rise; W1C 0x4 clears it; PEND[2] sets again on the fall.
REQ-040 W1C 0x1 to PEND in the same cycle ch0 event fires -> PEND[0] reads 1.
REQ-041 IE=0 with PEND[3]=1 -> irq_o=0; write IE=0x8 -> irq_o[3]=1 one cycle later.
REQ-042 rst pulsed at count 5 of a debounce -> all registers read 0; no PEND after release while input is stable.
